// File: rtl/slc_mem_access.sv
// ---------------------------------------------------------------------------
// slc_mem_access
// Memory access unit sitting between the SLC-3 control FSM and the off-chip
// SRAM plus the switch/hex I/O port. A level request (Mem_OE / Mem_WE) is
// sampled once in IDLE, turned into an SRAM strobe sequence lasting
// WAIT_CYCLES+1 cycles, and completion is flagged by a one-cycle Mem_Ready.
// Address IO_ADDR is redirected to the switches (read) and hex register
// (write) with the same latency as an SRAM access.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Mem_OE, Mem_WE        read / write request levels (write wins if both)
//   ADDR, Data_from_CPU   address and write data, latched in IDLE
//   Data_to_CPU           read data, valid from the DONE cycle onward
//   Mem_Ready             one-cycle completion pulse
//   Switches, HEX_Data    memory-mapped I/O
//   sram_*                SRAM address, active-low strobes, data buses
// ---------------------------------------------------------------------------
module slc_mem_access #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_Data,
  output logic [15:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  input  logic [15:0] sram_data_in,
  output logic [15:0] sram_data_out,
  output logic        sram_data_oe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } state_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [15:0] r_hex;
  logic        r_isWrite;
  logic        r_isIo;
  logic        r_ready;
  logic        r_ceN;
  logic        r_oeN;
  logic        r_weN;
  logic        r_dataOe;

  logic        w_req;
  logic        w_newIo;
  logic        w_lastAccess;

  assign w_req        = Mem_OE | Mem_WE;
  assign w_newIo      = (ADDR == IO_ADDR);
  assign w_lastAccess = (r_cnt == WAIT_C);

  // Single FSM process. The strobes are registered alongside the state so
  // that they are asserted exactly while the state register holds ACCESS and
  // are glitch-free at the pins; they are loaded from the values being
  // latched on the IDLE->ACCESS edge and cleared on the ACCESS->DONE edge.
  // Read data and the hex register are both loaded on the edge that enters
  // DONE, so the CPU sees them in the same cycle as Mem_Ready.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_rdata   <= 16'h0000;
      r_hex     <= 16'h0000;
      r_isWrite <= 1'b0;
      r_isIo    <= 1'b0;
      r_ready   <= 1'b0;
      r_ceN     <= 1'b1;
      r_oeN     <= 1'b1;
      r_weN     <= 1'b1;
      r_dataOe  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr    <= ADDR;
            r_wdata   <= Data_from_CPU;
            r_isWrite <= Mem_WE;
            r_isIo    <= w_newIo;
            r_cnt     <= 4'd0;
            r_ceN     <= w_newIo;
            r_oeN     <= Mem_WE | w_newIo;
            r_weN     <= ~Mem_WE | w_newIo;
            r_dataOe  <= Mem_WE & ~w_newIo;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_lastAccess) begin
            r_state  <= S_DONE;
            r_ready  <= 1'b1;
            r_ceN    <= 1'b1;
            r_oeN    <= 1'b1;
            r_weN    <= 1'b1;
            r_dataOe <= 1'b0;
            if (!r_isWrite) begin
              r_rdata <= r_isIo ? Switches : sram_data_in;
            end else if (r_isIo) begin
              r_hex <= r_wdata;
            end
          end
        end
        // A still-high level request must drop before IDLE may sample again.
        S_DONE: begin
          r_state <= w_req ? S_RELEASE : S_IDLE;
        end
        S_RELEASE: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Data_to_CPU   = r_rdata;
  assign Mem_Ready     = r_ready;
  assign HEX_Data      = r_hex;
  assign sram_addr     = r_addr;
  assign sram_data_out = r_wdata;
  assign sram_ce_n     = r_ceN;
  assign sram_oe_n     = r_oeN;
  assign sram_we_n     = r_weN;
  assign sram_data_oe  = r_dataOe;

endmodule

// File: tb/tb_slc_mem_access.sv
// ---------------------------------------------------------------------------
// tb_slc_mem_access
// Drives two instances of slc_mem_access (default WAIT_CYCLES=2 and a
// WAIT_CYCLES=0 build) with directed and random transactions. Expected
// outputs come from a transaction-level model: an access started in cycle 0
// occupies cycles 1..W+1, completes in cycle W+2, and updates the modelled
// read-data / hex registers at completion.
// ---------------------------------------------------------------------------
module tb_slc_mem_access;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Switches;
  logic [15:0] sram_data_in;

  // Request inputs are separate per instance so each runs its own sequence.
  logic        oe2, we2, oe0, we0;

  logic [15:0] dataToCpu2, hex2, sramAddr2, dataOut2;
  logic        ready2, ceN2, oeN2, weN2, dataOe2;
  logic [15:0] dataToCpu0, hex0, sramAddr0, dataOut0;
  logic        ready0, ceN0, oeN0, weN0, dataOe0;

  int passCount = 0;
  int checkCount = 0;

  logic [15:0] modelRd  [2];
  logic [15:0] modelHex [2];

  always #5 Clk = ~Clk;

  slc_mem_access #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut2 (
    .Clk(Clk), .Reset(Reset), .Mem_OE(oe2), .Mem_WE(we2),
    .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .Data_to_CPU(dataToCpu2),
    .Mem_Ready(ready2), .Switches(Switches), .HEX_Data(hex2),
    .sram_addr(sramAddr2), .sram_ce_n(ceN2), .sram_oe_n(oeN2),
    .sram_we_n(weN2), .sram_data_in(sram_data_in),
    .sram_data_out(dataOut2), .sram_data_oe(dataOe2)
  );

  slc_mem_access #(.WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(Clk), .Reset(Reset), .Mem_OE(oe0), .Mem_WE(we0),
    .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .Data_to_CPU(dataToCpu0),
    .Mem_Ready(ready0), .Switches(Switches), .HEX_Data(hex0),
    .sram_addr(sramAddr0), .sram_ce_n(ceN0), .sram_oe_n(oeN0),
    .sram_we_n(weN0), .sram_data_in(sram_data_in),
    .sram_data_out(dataOut0), .sram_data_oe(dataOe0)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic driveReq(input int idx, input logic rd, input logic wr);
    if (idx == 0) begin
      oe0 = rd;
      we0 = wr;
    end else begin
      oe2 = rd;
      we2 = wr;
    end
  endtask

  // Compare one instance's outputs with what the model says for this cycle.
  task automatic checkOutputs(input int idx, input string tag, input logic inAccess,
                              input logic expReady, input logic io, input logic wr,
                              input logic [15:0] expAddr, input logic [15:0] expWdata);
    logic [15:0] d, h, a, o;
    logic r, ce, oe, we, doe;
    logic sram;
    if (idx == 0) begin
      d = dataToCpu0; h = hex0; a = sramAddr0; o = dataOut0;
      r = ready0; ce = ceN0; oe = oeN0; we = weN0; doe = dataOe0;
    end else begin
      d = dataToCpu2; h = hex2; a = sramAddr2; o = dataOut2;
      r = ready2; ce = ceN2; oe = oeN2; we = weN2; doe = dataOe2;
    end
    sram = inAccess && !io;
    chk({tag, ".ready"},  16'(r),   16'(expReady));
    chk({tag, ".ce_n"},   16'(ce),  16'(!sram));
    chk({tag, ".oe_n"},   16'(oe),  16'(!(sram && !wr)));
    chk({tag, ".we_n"},   16'(we),  16'(!(sram && wr)));
    chk({tag, ".dataOe"}, 16'(doe), 16'(sram && wr));
    chk({tag, ".rdata"},  d, modelRd[idx]);
    chk({tag, ".hex"},    h, modelHex[idx]);
    chk({tag, ".addr"},   a, expAddr);
    chk({tag, ".wdata"},  o, expWdata);
  endtask

  // One complete transaction, entered and left with the instance in IDLE.
  task automatic applyStimulus(input int idx, input int w, input string tag,
                               input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] sw, input logic [15:0] sramIn,
                               input int hold);
    logic io;
    io = (addr == 16'hFFFF);
    ADDR = addr;
    Data_from_CPU = wdata;
    Switches = sw;
    sram_data_in = sramIn;
    driveReq(idx, rd, wr);
    for (int k = 1; k <= w + 2; k++) begin
      tick();
      if (k == 1) begin
        ADDR = 16'($urandom);
        Data_from_CPU = 16'($urandom);
      end
      if (k == w + 2) begin
        if (wr) begin
          if (io) modelHex[idx] = wdata;
        end else begin
          modelRd[idx] = io ? sw : sramIn;
        end
      end
      checkOutputs(idx, tag, (k <= w + 1), (k == w + 2), io, wr, addr, wdata);
    end
    for (int j = 0; j < hold; j++) begin
      tick();
      checkOutputs(idx, {tag, ".rel"}, 1'b0, 1'b0, io, wr, addr, wdata);
    end
    driveReq(idx, 1'b0, 1'b0);
    if (hold > 0) begin
      tick();
      checkOutputs(idx, {tag, ".idle"}, 1'b0, 1'b0, io, wr, addr, wdata);
    end
    tick();
  endtask

  task automatic doReset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      modelRd[i] = 16'h0000;
      modelHex[i] = 16'h0000;
    end
  endtask

  initial begin
    int idx, w, op, hold;
    logic [15:0] a;
    Reset = 1'b1;
    oe2 = 0; we2 = 0; oe0 = 0; we0 = 0;
    ADDR = 0; Data_from_CPU = 0; Switches = 0; sram_data_in = 0;
    doReset();

    // Idle after reset: everything at reset values for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutputs(1, "reset2", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      checkOutputs(0, "reset0", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end

    // Reset in the second ACCESS cycle of an I/O write: nothing completes.
    ADDR = 16'hFFFF; Data_from_CPU = 16'h5A5A; driveReq(1, 1'b0, 1'b1);
    tick();
    tick();
    Reset = 1'b1; driveReq(1, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
    checkOutputs(1, "rstIo", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutputs(1, "rstIoAfter", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    end

    // Reset mid SRAM write: strobes must fall back at the next edge.
    ADDR = 16'h0100; Data_from_CPU = 16'h7777; driveReq(1, 1'b0, 1'b1);
    tick();
    tick();
    checkOutputs(1, "rstSramPre", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h7777);
    Reset = 1'b1; driveReq(1, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
    checkOutputs(1, "rstSram", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    tick();

    // Directed transactions on the default build.
    applyStimulus(1, 2, "sramRead",  1'b1, 1'b0, 16'h3000, 16'h0000, 16'h0000, 16'hBEEF, 3);
    applyStimulus(1, 2, "sramWrite", 1'b0, 1'b1, 16'h0042, 16'h1234, 16'h0000, 16'hDEAD, 2);
    applyStimulus(1, 2, "ioRead",    1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h1111, 0);
    applyStimulus(1, 2, "ioWrite",   1'b0, 1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 16'h2222, 0);
    applyStimulus(1, 2, "bothHigh",  1'b1, 1'b1, 16'h0200, 16'hC0DE, 16'h0000, 16'h3333, 1);
    applyStimulus(1, 2, "bothIo",    1'b1, 1'b1, 16'hFFFF, 16'h0F0F, 16'hFFFF, 16'h4444, 0);

    // Zero-wait-state build.
    applyStimulus(0, 0, "w0Read",  1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 16'hCAFE, 1);
    applyStimulus(0, 0, "w0Write", 1'b0, 1'b1, 16'hFFFF, 16'hA1B2, 16'h0000, 16'h0000, 0);

    // Random transactions on both builds.
    for (int i = 0; i < 24; i++) begin
      idx  = (i % 3 == 0) ? 0 : 1;
      w    = (idx == 0) ? 0 : 2;
      op   = $urandom_range(0, 2);
      a    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      hold = $urandom_range(0, 2);
      applyStimulus(idx, w, "rand", (op != 1), (op != 0), a, 16'($urandom),
                    16'($urandom), 16'($urandom), hold);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
